// File: rtl/multi_nibble_adder_pkg.sv
// multi_nibble_adder_pkg: shared constants, FSM states and index-width helper
package multi_nibble_adder_pkg;
    localparam int NIB_W = 4;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    function automatic int clog2(input int n);
        int r = 1;
        while ((1 << r) < n) r++;
        return r;
    endfunction
endpackage

// File: rtl/multi_nibble_adder_nibble_adder.sv
// nibble_adder: combinational 4-bit ripple adder slice
module nibble_adder
    import multi_nibble_adder_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             carry
);
    assign {carry, sum} = {1'b0, a} + {1'b0, b} + {{NIB_W{1'b0}}, cin};
endmodule

// File: rtl/multi_nibble_adder.sv
// multi_nibble_adder: adds two NIBBLES*4-bit operands one nibble per clock
// through a single time-multiplexed nibble adder, with a start/done handshake
module multi_nibble_adder
    import multi_nibble_adder_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NIB_W*NIBBLES-1:0]   a,
    input  logic [NIB_W*NIBBLES-1:0]   b,
    input  logic                       cin,
    output logic                       busy,
    output logic                       done,
    output logic [NIB_W*NIBBLES-1:0]   sum,
    output logic                       cout,
    output logic                       ovf
);
    localparam int IW = clog2(NIBBLES);
    state_t state, state_nx;
    logic [NIBBLES-1:0][NIB_W-1:0] opa, opb, sum_r;
    logic carry;
    logic [IW-1:0] idx;
    logic [NIB_W-1:0] ns;
    logic nc, last, accept;
    nibble_adder u_nib (
        .a     (opa[idx]),
        .b     (opb[idx]),
        .cin   (carry),
        .sum   (ns),
        .carry (nc)
    );
    assign last   = idx == IW'(NIBBLES - 1);
    assign accept = state != RUN && start;
    assign sum    = sum_r;
    always_comb begin
        state_nx = accept ? RUN : (state == RUN) ? (last ? DONE : RUN) : IDLE;
    end
    // busy/done come straight from flops so consumers see clean decodes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            sum_r <= '0;
            carry <= 1'b0;
            idx   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= state_nx == RUN;
            done  <= state_nx == DONE;
            if (accept) begin
                opa   <= a;
                opb   <= b;
                carry <= cin;
                idx   <= '0;
            end else if (state == RUN) begin
                sum_r[idx] <= ns;
                carry      <= nc;
                idx        <= last ? '0 : idx + IW'(1);
                if (last) begin
                    cout <= nc;
                    ovf  <= (opa[NIBBLES-1][NIB_W-1] == opb[NIBBLES-1][NIB_W-1]) &&
                            (ns[NIB_W-1] != opa[NIBBLES-1][NIB_W-1]);
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_nibble_adder.sv
// tb_multi_nibble_adder: scoreboard bench with directed and random additions
module tb_multi_nibble_adder;
    localparam int N = 4;
    localparam int W = 4 * N;
    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0, cin = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done, cout, ovf;
    logic [W-1:0] sum;
    int cyc = 0, checks = 0, errors = 0;
    exp_t q[$];
    multi_nibble_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask
    function automatic exp_t model(input logic [W-1:0] x, y, input logic c, input int k);
        exp_t e;
        longint sx, sy, tot;
        logic [W:0] full;
        full = W'(x) + W'(y) + c;
        full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
        sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
        sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
        tot = sx + sy + longint'(c);
        e.s = full[W-1:0];
        e.c = full[W];
        e.o = (tot > (longint'(1) << (W - 1)) - 1) || (tot < -(longint'(1) << (W - 1)));
        e.cyc = k + N;
        return e;
    endfunction
    always @(negedge clk) begin
        if (!rst && done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("sum", 32'(sum), 32'(e.s));
                chk("cout", 32'(cout), 32'(e.c));
                chk("ovf", 32'(ovf), 32'(e.o));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
                chk("busy_at_done", 32'(busy), 32'd0);
            end
        end
    end
    task automatic issue(input logic [W-1:0] x, y, input logic c, input bit track);
        @(negedge clk);
        a = x;
        b = y;
        cin = c;
        start = 1'b1;
        @(posedge clk);
        #1;
        if (track) q.push_back(model(x, y, c, cyc));
    endtask
    task automatic wait_idle();
        for (int i = 0; i < 50 && q.size() != 0; i++) @(posedge clk);
        chk("drain_timeout", 32'(q.size()), 32'd0);
        q.delete();
    endtask
    task automatic run_op(input logic [W-1:0] x, y, input logic c);
        issue(x, y, c, 1'b1);
        @(negedge clk);
        start = 1'b0;
        wait_idle();
    endtask
    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_sum"}, 32'(sum), 32'd0);
        chk({tag, "_cout"}, 32'(cout), 32'd0);
        chk({tag, "_ovf"}, 32'(ovf), 32'd0);
    endtask
    initial begin
        #1;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        run_op(16'h1234, 16'h4321, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0);
        run_op(16'h7FFF, 16'h0000, 1'b1);
        run_op(16'h8000, 16'h8000, 1'b0);
        // a start during RUN must not disturb the operation in flight
        issue(16'h1111, 16'h1111, 1'b0, 1'b1);
        @(negedge clk);
        a = 16'h0F0F;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        issue(16'h1234, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk_reset("midrun_reset");
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        run_op(16'h0001, 16'h0001, 1'b0);
        issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        for (int i = 0; i < 9; i++) begin
            repeat (N) @(negedge clk);
            issue(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        end
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
